// File: rtl/primes_seq.sv
// primes_seq: multi-cycle prime classifier using trial division by odd
// divisors, with division done by repeated subtraction.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request, only sampled while idle
//   in       WIDTH-bit operand, captured on the accepted start edge
//   busy     high whenever the unit is not idle
//   done     one-cycle pulse, isprime valid
//   isprime  result, held until the next done
module primes_seq #(
    parameter int WIDTH        = 8,
    parameter bit ONE_IS_PRIME = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    output logic             busy,
    output logic             done,
    output logic             isprime
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        TEST,
        DIV,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] n_nxt;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] r_nxt;
    logic [WIDTH:0]   d;
    logic [WIDTH:0]   d_nxt;
    logic             res;
    logic             res_nxt;

    // Square of the divisor at double width so it can never wrap.
    logic [2*WIDTH+1:0] dsq;
    logic [WIDTH:0]     rx;

    assign dsq = {{(WIDTH+1){1'b0}}, d} * {{(WIDTH+1){1'b0}}, d};
    assign rx  = {1'b0, r};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            n     <= '0;
            r     <= '0;
            d     <= '0;
            res   <= 1'b0;
        end else begin
            state <= state_nxt;
            n     <= n_nxt;
            r     <= r_nxt;
            d     <= d_nxt;
            res   <= res_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        n_nxt     = n;
        r_nxt     = r;
        d_nxt     = d;
        res_nxt   = res;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    n_nxt     = in;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (n == WIDTH'(0)) begin
                    res_nxt   = 1'b0;
                    state_nxt = DONE;
                end else if (n == WIDTH'(1)) begin
                    res_nxt   = ONE_IS_PRIME;
                    state_nxt = DONE;
                end else if (n == WIDTH'(2) || n == WIDTH'(3)) begin
                    res_nxt   = 1'b1;
                    state_nxt = DONE;
                end else if (!n[0]) begin
                    res_nxt   = 1'b0;
                    state_nxt = DONE;
                end else begin
                    d_nxt     = (WIDTH+1)'(3);
                    r_nxt     = n;
                    state_nxt = TEST;
                end
            end
            TEST: begin
                if (dsq > {{(WIDTH+2){1'b0}}, n}) begin
                    res_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    state_nxt = DIV;
                end
            end
            DIV: begin
                // r >= d implies d fits in WIDTH bits here.
                if (rx >= d) begin
                    r_nxt = r - d[WIDTH-1:0];
                end else if (r == '0) begin
                    res_nxt   = 1'b0;
                    state_nxt = DONE;
                end else begin
                    d_nxt     = d + (WIDTH+1)'(2);
                    r_nxt     = n;
                    state_nxt = TEST;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign isprime = res;

endmodule

// File: tb/tb_primes_seq.sv
// tb_primes_seq: checks primes_seq in four parameter configurations
// against an arithmetic reference for primality and latency.
module tb_primes_seq;

    logic        clk;
    logic        rst_n;
    logic [3:0]  start;
    logic [11:0] din;
    logic [3:0]  busy;
    logic [3:0]  done;
    logic [3:0]  isprime;

    int tests;
    int fails;

    primes_seq #(.WIDTH(4), .ONE_IS_PRIME(1'b1)) u_w4 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .in(din[3:0]),
        .busy(busy[0]), .done(done[0]), .isprime(isprime[0])
    );

    primes_seq #(.WIDTH(8), .ONE_IS_PRIME(1'b1)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .in(din[7:0]),
        .busy(busy[1]), .done(done[1]), .isprime(isprime[1])
    );

    primes_seq #(.WIDTH(8), .ONE_IS_PRIME(1'b0)) u_w8z (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .in(din[7:0]),
        .busy(busy[2]), .done(done[2]), .isprime(isprime[2])
    );

    primes_seq #(.WIDTH(12), .ONE_IS_PRIME(1'b1)) u_w12 (
        .clk(clk), .rst_n(rst_n), .start(start[3]), .in(din),
        .busy(busy[3]), .done(done[3]), .isprime(isprime[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit ref_prime(input int v, input bit one);
        if (v < 2) return (v == 1) ? one : 1'b0;
        for (int k = 2; k * k <= v; k++)
            if (v % k == 0) return 1'b0;
        return 1'b1;
    endfunction

    // Edges from accept to done: accept + CHECK, then per odd divisor one
    // TEST edge plus v/k subtractions plus the final remainder decision;
    // a prime ends on one extra TEST edge.
    function automatic int ref_lat(input int v);
        int l;
        if (v < 4 || v % 2 == 0) return 2;
        l = 2;
        for (int k = 3; k * k <= v; k += 2) begin
            l += 2 + v / k;
            if (v % k == 0) return l;
        end
        return l + 1;
    endfunction

    task automatic wait_done(input int u, input int lat0,
                             output bit p, output int lat, output int nd);
        bit seen;
        seen = 1'b0;
        nd   = 0;
        p    = 1'b0;
        lat  = lat0;
        while (!seen && lat < 20000) begin
            @(posedge clk);
            lat++;
            #1;
            if (done[u]) begin
                seen = 1'b1;
                p    = isprime[u];
                nd   = 1;
            end
        end
        if (!seen) lat = -1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (done[u]) nd++;
        end
    endtask

    task automatic run_op(input int u, input int val,
                          output bit p, output int lat, output int nd);
        @(negedge clk);
        din      = 12'(val);
        start[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[u] = 1'b0;
        din      = 12'($urandom);
        wait_done(u, 1, p, lat, nd);
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        start = '0;
        din   = '0;
        #1 rst_n = 1'b0;
        #2;
        tests++;
        if (busy !== 4'b0) begin
            fails++;
            $display("FAIL reset_busy got=%b want=0000", busy);
        end
        tests++;
        if (done !== 4'b0) begin
            fails++;
            $display("FAIL reset_done got=%b want=0000", done);
        end
        tests++;
        if (isprime !== 4'b0) begin
            fails++;
            $display("FAIL reset_isprime got=%b want=0000", isprime);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_w4_table;
        logic [15:0] legacy;
        bit          p;
        int          lat;
        int          nd;
        legacy = 16'h28AE;
        for (int v = 0; v < 16; v++) begin
            run_op(0, v, p, lat, nd);
            tests++;
            if (p !== legacy[v] || nd != 1 || lat != ref_lat(v)) begin
                fails++;
                $display("FAIL w4_n%0d got p=%0d lat=%0d nd=%0d want p=%0d lat=%0d nd=1",
                         v, p, lat, nd, legacy[v], ref_lat(v));
            end
        end
    endtask

    task automatic test_latency;
        int vals[4] = '{4, 7, 9, 25};
        int lats[4] = '{2, 3, 7, 19};
        bit prm[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        bit p;
        int lat;
        int nd;
        for (int i = 0; i < 4; i++) begin
            run_op(1, vals[i], p, lat, nd);
            tests++;
            if (p !== prm[i] || lat != lats[i] || nd != 1) begin
                fails++;
                $display("FAIL lat_n%0d got p=%0d lat=%0d nd=%0d want p=%0d lat=%0d nd=1",
                         vals[i], p, lat, nd, prm[i], lats[i]);
            end
        end
    endtask

    task automatic test_one_not_prime;
        int vals[4] = '{1, 251, 255, 0};
        bit prm[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        bit p;
        int lat;
        int nd;
        for (int i = 0; i < 4; i++) begin
            run_op(2, vals[i], p, lat, nd);
            tests++;
            if (p !== prm[i] || nd != 1 || lat != ref_lat(vals[i])) begin
                fails++;
                $display("FAIL onez_n%0d got p=%0d lat=%0d nd=%0d want p=%0d lat=%0d nd=1",
                         vals[i], p, lat, nd, prm[i], ref_lat(vals[i]));
            end
        end
    endtask

    task automatic test_busy_ignore;
        bit p;
        int lat;
        int nd;
        @(negedge clk);
        din      = 12'd251;
        start[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[1] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        tests++;
        if (busy[1] !== 1'b1) begin
            fails++;
            $display("FAIL busy_mid got=%b want=1", busy[1]);
        end
        din      = 12'd4;
        start[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[1] = 1'b0;
        wait_done(1, 6, p, lat, nd);
        tests++;
        if (p !== 1'b1 || nd != 1 || lat != ref_lat(251)) begin
            fails++;
            $display("FAIL busy_ignore got p=%0d lat=%0d nd=%0d want p=1 lat=%0d nd=1",
                     p, lat, nd, ref_lat(251));
        end
    endtask

    task automatic test_reset_mid;
        bit p;
        int lat;
        int nd;
        @(negedge clk);
        din      = 12'd253;
        start[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[1] = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        tests++;
        if (busy[1] !== 1'b1 || isprime[1] !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset got busy=%b isprime=%b want busy=1 isprime=1",
                     busy[1], isprime[1]);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({busy[1], done[1], isprime[1]} !== 3'b000) begin
            fails++;
            $display("FAIL async_reset got busy/done/isprime=%b want=000",
                     {busy[1], done[1], isprime[1]});
        end
        nd = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done[1]) nd++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done[1]) nd++;
        end
        tests++;
        if (nd != 0) begin
            fails++;
            $display("FAIL reset_no_done got=%0d done pulses want=0", nd);
        end
        run_op(1, 13, p, lat, nd);
        tests++;
        if (p !== 1'b1 || nd != 1 || lat != ref_lat(13)) begin
            fails++;
            $display("FAIL after_reset_n13 got p=%0d lat=%0d nd=%0d want p=1 lat=%0d nd=1",
                     p, lat, nd, ref_lat(13));
        end
    endtask

    task automatic test_back_to_back;
        int nd;
        int first;
        int second;
        nd     = 0;
        first  = -1;
        second = -1;
        @(negedge clk);
        din      = 12'd4;
        start[1] = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1;
            if (done[1]) begin
                nd++;
                if (first < 0) first = e;
                else second = e;
            end
        end
        @(negedge clk);
        start[1] = 1'b0;
        repeat (4) @(posedge clk);
        tests++;
        if (nd != 2 || first != 2 || second != 5) begin
            fails++;
            $display("FAIL back_to_back got nd=%0d at %0d,%0d want nd=2 at 2,5",
                     nd, first, second);
        end
    endtask

    task automatic test_random;
        bit p;
        int lat;
        int nd;
        int v;
        for (int i = 0; i < 25; i++) begin
            v = (i % 3 == 0) ? int'($urandom_range(0, 63))
                             : int'($urandom_range(0, 4095));
            run_op(3, v, p, lat, nd);
            tests++;
            if (p !== ref_prime(v, 1'b1) || nd != 1 || lat != ref_lat(v)) begin
                fails++;
                $display("FAIL rand_n%0d got p=%0d lat=%0d nd=%0d want p=%0d lat=%0d nd=1",
                         v, p, lat, nd, ref_prime(v, 1'b1), ref_lat(v));
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset;
        test_w4_table;
        test_latency;
        test_one_not_prime;
        test_busy_ignore;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
